// File: rtl/elevator_queue.sv
// Four-floor elevator controller: synchronised floor calls feed a
// deduplicated FIFO that the car serves strictly in arrival order.
module elevator_queue #(
    parameter int MOVE_TICKS = 12_000_000,
    parameter int DOOR_TICKS = 24_000_000
) (
    input  logic       clk,
    input  logic [4:0] pmod,
    output logic [4:0] led
);

    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MOVING = 2'd1;
    localparam logic [1:0] DOOR   = 2'd2;

    logic       rst;
    logic [3:0] btn;

    assign rst = pmod[4];
    assign btn = pmod[3:0];

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] rise;
    logic [3:0] pending;

    logic [1:0] fifo [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] count;
    logic [3:0] queued;
    logic [1:0] head;

    logic [1:0]    state;
    logic [1:0]    floor;
    logic [1:0]    target;
    logic          dir_up;
    logic [MW-1:0] move_cnt;
    logic [DW-1:0] door_cnt;

    logic [1:0]    state_n;
    logic [1:0]    floor_n;
    logic [1:0]    target_n;
    logic          dir_n;
    logic [MW-1:0] move_n;
    logic [DW-1:0] door_n;
    logic [1:0]    step;
    logic          pop;

    logic [1:0] sel_idx;
    logic [3:0] sel_bit;
    logic       have_pending;
    logic       push;

    assign head = fifo[rptr];

    // Lowest-index pending floor is offered to the queue each cycle.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 2'(i);
            end
        end
    end

    assign have_pending = |pending;
    assign sel_bit      = have_pending ? (4'b0001 << sel_idx) : 4'b0000;
    assign push         = have_pending && !queued[sel_idx] && (count != 3'd4);

    always_comb begin
        if (dir_up) begin
            step = (floor == 2'd3) ? 2'd3 : floor + 2'd1;
        end else begin
            step = (floor == 2'd0) ? 2'd0 : floor - 2'd1;
        end
    end

    always_comb begin
        state_n  = state;
        floor_n  = floor;
        target_n = target;
        dir_n    = dir_up;
        move_n   = move_cnt;
        door_n   = door_cnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    if (head == floor) begin
                        pop     = 1'b1;
                        door_n  = '0;
                        state_n = DOOR;
                    end else begin
                        target_n = head;
                        dir_n    = (head > floor);
                        move_n   = '0;
                        state_n  = MOVING;
                    end
                end
            end
            MOVING: begin
                if (move_cnt == MOVE_LAST) begin
                    move_n  = '0;
                    floor_n = step;
                    if (step == target) begin
                        pop     = 1'b1;
                        door_n  = '0;
                        state_n = DOOR;
                    end
                end else begin
                    move_n = move_cnt + MW'(1);
                end
            end
            DOOR: begin
                if (door_cnt == DOOR_LAST) begin
                    door_n  = '0;
                    state_n = IDLE;
                end else begin
                    door_n = door_cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            rise    <= '0;
            pending <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync3   <= sync2;
            rise    <= sync2 & ~sync3;
            pending <= (pending & ~sel_bit) | rise;
        end
    end

    // Storage needs no reset; the pointers and count define emptiness.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo[wptr] <= sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            queued <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            queued <= (queued & ~(pop ? (4'b0001 << head) : 4'b0000))
                    | (push ? sel_bit : 4'b0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            floor    <= 2'd0;
            target   <= 2'd0;
            dir_up   <= 1'b0;
            move_cnt <= '0;
            door_cnt <= '0;
            led      <= 5'b00001;
        end else begin
            state    <= state_n;
            floor    <= floor_n;
            target   <= target_n;
            dir_up   <= dir_n;
            move_cnt <= move_n;
            door_cnt <= door_n;
            led      <= {state_n == DOOR, 4'b0001 << floor_n};
        end
    end

endmodule

// File: tb/tb_elevator_queue.sv
// Directed cycle-exact bench for elevator_queue with short move/door
// intervals; every expected led value is worked out by hand.
module tb_elevator_queue;

    logic       clk;
    logic [4:0] pmod;
    logic [4:0] led;

    int n_checks;
    int n_pass;

    elevator_queue #(
        .MOVE_TICKS(4),
        .DOOR_TICKS(3)
    ) dut (
        .clk (clk),
        .pmod(pmod),
        .led (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got,
                         input logic [4:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: led=%b expected %b", tag, got, exp);
        end
    endtask

    // n edges, led checked 1 ns after each
    task automatic run(input string tag, input logic [4:0] exp,
                       input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check(tag, led, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        pmod = 5'b10000;
        run(tag, 5'b00001, 2);
        pmod = 5'b00000;
    endtask

    initial begin
        logic [4:0] seen;
        n_checks = 0;
        n_pass   = 0;
        pmod     = 5'b10000;

        // reset only, then 10 us idle
        do_reset("rst");
        seen = 5'b00001;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (led !== 5'b00001) seen = led;
        end
        check("idle_hold", seen, 5'b00001);

        // single call to floor 2
        pmod = 5'b00100;
        run("c2_press", 5'b00001, 1);
        pmod = 5'b00000;
        run("c2_f0", 5'b00001, 8);
        run("c2_f1", 5'b00010, 4);
        run("c2_door", 5'b10100, 3);
        run("c2_idle", 5'b00100, 3);

        // own-floor call at floor 0
        do_reset("rst_own");
        pmod = 5'b00001;
        run("own_press", 5'b00001, 1);
        pmod = 5'b00000;
        run("own_wait", 5'b00001, 4);
        run("own_door", 5'b10001, 3);
        run("own_idle", 5'b00001, 3);

        // held button gives a single request
        pmod = 5'b00001;
        run("hold_wait", 5'b00001, 5);
        run("hold_door", 5'b10001, 3);
        pmod = 5'b00000;
        run("hold_idle", 5'b00001, 12);

        // call to current floor during DOOR: second door cycle
        pmod = 5'b00001;
        run("dd_press", 5'b00001, 1);
        pmod = 5'b00000;
        run("dd_wait", 5'b00001, 4);
        pmod = 5'b00001;
        run("dd_door1", 5'b10001, 1);
        pmod = 5'b00000;
        run("dd_door1", 5'b10001, 2);
        run("dd_gap", 5'b00001, 2);
        run("dd_door2", 5'b10001, 3);
        run("dd_idle", 5'b00001, 6);

        // FIFO order 3 then 1, repeated 3 deduplicated
        do_reset("rst_fifo");
        pmod = 5'b01000;
        run("ff_p3", 5'b00001, 1);
        pmod = 5'b00010;
        run("ff_p1", 5'b00001, 1);
        pmod = 5'b01000;
        run("ff_p3b", 5'b00001, 1);
        pmod = 5'b00000;
        run("ff_f0", 5'b00001, 6);
        run("ff_up1", 5'b00010, 4);
        run("ff_up2", 5'b00100, 4);
        run("ff_door3", 5'b11000, 3);
        run("ff_at3", 5'b01000, 5);
        run("ff_dn2", 5'b00100, 4);
        run("ff_door1", 5'b10010, 3);
        run("ff_idle1", 5'b00010, 14);

        // simultaneous 1 and 3: floor 1 first
        do_reset("rst_sim");
        pmod = 5'b01010;
        run("sim_press", 5'b00001, 1);
        pmod = 5'b00000;
        run("sim_f0", 5'b00001, 8);
        run("sim_door1", 5'b10010, 3);
        run("sim_at1", 5'b00010, 5);
        run("sim_f2", 5'b00100, 4);
        run("sim_door3", 5'b11000, 3);
        run("sim_idle3", 5'b01000, 7);

        // reset while moving between floors 1 and 2
        do_reset("rst_mm0");
        pmod = 5'b01000;
        run("mm_p3", 5'b00001, 1);
        pmod = 5'b00001;
        run("mm_p0", 5'b00001, 1);
        pmod = 5'b00000;
        run("mm_f0", 5'b00001, 7);
        run("mm_f1", 5'b00010, 2);
        pmod = 5'b10000;
        run("mm_rst", 5'b00001, 1);
        pmod = 5'b00000;
        run("mm_quiet", 5'b00001, 30);
        pmod = 5'b00010;
        run("mm_p1", 5'b00001, 1);
        pmod = 5'b00000;
        run("mm_go", 5'b00001, 8);
        run("mm_door1", 5'b10010, 3);
        run("mm_idle1", 5'b00010, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
